trng_fifo_ctrl: RTL
===================

# trng_fifo_ctrl

Sequencing controller that sits between the TRNG bit sampler and the 32-bit word FIFO. It discards a warm-up run of raw bits, packs accepted random bits into 32-bit words, and pushes each word into the FIFO, dropping and counting words when the FIFO is full. On the read side it pops words from the FIFO and presents them to the host through a valid/ready output register.

## Interface
- `WARMUP`, default 64: number of `bit_valid` bits discarded after enable rises or after a health failure; range 1..65535.
- `CNT_W`, default 8: width of the dropped-word counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: collection enable, level.
- `bit_valid` in 1: `bit_in` is valid this cycle.
- `bit_in` in 1: raw entropy bit.
- `health_fail` in 1: health-test failure pulse; discards the partial word and restarts warm-up.
- `ovf_clr` in 1: clears `overflow` and `drop_cnt`.
- `fifo_wr_en` out 1: FIFO write strobe, one-cycle pulse.
- `fifo_wr_data` out 32: packed word.
- `fifo_full` in 1: FIFO full flag.
- `fifo_rd_en` out 1: FIFO read strobe, one-cycle pulse.
- `fifo_rd_data` in 32: registered FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `m_valid` out 1: host word valid.
- `m_data` out 32: host word.
- `m_ready` in 1: host accepts the word.
- `collecting` out 1: high in state COLLECT.
- `overflow` out 1: sticky; a word was dropped.
- `drop_cnt` out `CNT_W`: saturating count of dropped words.

## Operation
- **Reset** (`rst_n`=0 at an edge): all outputs are 0, the fill FSM is in IDLE, the read FSM is in R_IDLE, and the shift register, bit counter and warm-up counter are 0. Reset mid-word or mid-read abandons the operation with no write or pop.
- **Fill FSM: IDLE -> WARMUP -> COLLECT.**
  - IDLE -> WARMUP when `enable`=1.
  - WARMUP counts `bit_valid` cycles. After the `WARMUP`-th counted bit it moves to COLLECT; that bit is discarded.
  - In COLLECT, each `bit_valid` bit shifts into the word. The first accepted bit lands in bit 0 and the 32nd accepted bit in bit 31.
  - `enable`=0 in any state: go to IDLE and clear the partial word, bit counter and warm-up counter. FIFO contents are untouched.
  - `health_fail`=1 in WARMUP or COLLECT: go to WARMUP, clear the partial word and restart the warm-up count. `health_fail` takes priority over a bit arriving in the same cycle. `enable`=0 takes priority over `health_fail`.
- **Word completion**, on the edge that samples the 32nd bit:
  - If `fifo_full`=0, `fifo_wr_en`=1 with `fifo_wr_data`=word during the next cycle.
  - If `fifo_full`=1, no write: `overflow`<=1 and `drop_cnt` increments, saturating at 2^`CNT_W`-1.
  - The bit counter wraps to 0 and collection continues without gaps.
- **`ovf_clr`** sets `overflow`<=0 and `drop_cnt`<=0. If a drop happens in the same cycle, the drop wins: `overflow`=1 and `drop_cnt`=1.
- **Read FSM: R_IDLE -> R_ISSUE -> R_WAIT -> R_HOLD -> R_IDLE.** It runs regardless of `enable`.
  - R_IDLE -> R_ISSUE when `fifo_empty`=0.
  - R_ISSUE: `fifo_rd_en`=1 for exactly one cycle, then R_WAIT.
  - R_WAIT: `m_data`<=`fifo_rd_data` and `m_valid`<=1, then R_HOLD.
  - R_HOLD: `m_data` is held stable. When `m_valid`&&`m_ready` at an edge, `m_valid`<=0 and the FSM returns to R_IDLE.
- Only one pop is ever in flight. `fifo_rd_en` is never asserted while `m_valid`=1.

## Timing
- Bit to FIFO: the 32nd bit is sampled at edge E, and `fifo_wr_en` is high in cycle E+1 only.
- FIFO to host:
  - `fifo_rd_en` is high in cycle N.
  - `fifo_rd_data` is valid in cycle N+1.
  - `m_valid`=1 from cycle N+2.
- Handshake: a word accepted at edge A gives `m_valid`=0 in cycle A+1. The earliest next `fifo_rd_en` is cycle A+2.
- Sustained throughput: one word per 4 cycles when `m_ready` is held at 1.
- Write and pop in the same cycle are legal; the FIFO keeps its count.
- The `fifo_full` decision uses the value sampled at edge E. A pop issued in the same cycle does not rescue the word.
- `collecting` is registered from the state and goes high the cycle after the last warm-up bit.

## Test plan
1. **Basic fill and read.** `WARMUP`=4. Reset, set `enable`=1, send 4 discard bits then 32 bits of pattern 0xA5A5_00FF, LSB first, `m_ready`=1.
   - Required: exactly one `fifo_wr_en` pulse with 0xA5A5_00FF, 1 cycle after the last bit.
   - Required: `m_data`=0xA5A5_00FF with `m_valid` 2 cycles after `fifo_rd_en`.
2. **Overflow.** Hold `fifo_full`=1 and send 3 full words.
   - Required: no `fifo_wr_en`, `overflow`=1, `drop_cnt`=3.
   - Then pulse `ovf_clr` in the same cycle as a 4th drop. Required: `overflow`=1, `drop_cnt`=1.
3. **Health failure mid-word.** Send 20 bits, pulse `health_fail` together with bit 21.
   - Required: `collecting`=0, no write.
   - After 4 warm-up bits plus 32 new bits, the written word contains only the new bits.
4. **Back-pressure.** Preload the FIFO with 3 words, hold `m_ready`=0 for 10 cycles, then set it to 1.
   - Required: exactly one `fifo_rd_en` before release, `m_data` stable, and the 3 words delivered in order at 4-cycle spacing.
5. **Disable and reset mid-operation.**
   - Drop `enable` after 16 bits. Required: partial word discarded and FIFO words still readable.
   - Assert `rst_n`=0 in R_WAIT. Required: all outputs 0 at the next edge, and no `m_valid` for that pop.

Source files
------------

// File: rtl/trng_fifo_ctrl.sv
// trng_fifo_ctrl: discards a warm-up run of TRNG bits, packs accepted bits
// LSB-first into 32-bit words for the word FIFO (counting drops when full),
// and moves FIFO words to the host through a valid/ready output register.
//
// Fill FSM
//   state     | meaning
//   S_IDLE    | collection disabled, all fill counters cleared
//   S_WARMUP  | counting bit_valid bits that are thrown away
//   S_COLLECT | shifting accepted bits into the word
//
// Read FSM
//   state     | meaning
//   R_IDLE    | waiting for the FIFO to hold a word
//   R_ISSUE   | fifo_rd_en high for this single cycle
//   R_WAIT    | FIFO read data valid, captured into m_data at the edge
//   R_HOLD    | m_valid high, waiting for the host handshake
module trng_fifo_ctrl #(
   parameter int WARMUP = 64,
   parameter int CNT_W  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_bit_valid,
   input  logic             i_bit_in,
   input  logic             i_health_fail,
   input  logic             i_ovf_clr,
   output logic             o_fifo_wr_en,
   output logic [31:0]      o_fifo_wr_data,
   input  logic             i_fifo_full,
   output logic             o_fifo_rd_en,
   input  logic [31:0]      i_fifo_rd_data,
   input  logic             i_fifo_empty,
   output logic             o_m_valid,
   output logic [31:0]      o_m_data,
   input  logic             i_m_ready,
   output logic             o_collecting,
   output logic             o_overflow,
   output logic [CNT_W-1:0] o_drop_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT} fill_t;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_HOLD} rd_t;

   localparam logic [15:0]      WARM_LAST = 16'(WARMUP - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   fill_t       r_fill, w_fill_next;
   rd_t         r_rd, w_rd_next;
   logic [31:0] r_shift;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_warm_cnt;

   logic        w_restart;
   logic        w_warm_bit;
   logic        w_warm_done;
   logic        w_accept;
   logic        w_word_done;
   logic        w_drop;
   logic [31:0] w_word;

   // enable low outranks health_fail; both clear the partial word and counters
   assign w_restart   = !i_enable || i_health_fail;
   assign w_warm_bit  = (r_fill == S_WARMUP) && i_bit_valid && !w_restart;
   assign w_warm_done = w_warm_bit && (r_warm_cnt == WARM_LAST);
   assign w_accept    = (r_fill == S_COLLECT) && i_bit_valid && !w_restart;
   assign w_word_done = w_accept && (r_bit_cnt == 5'd31);
   assign w_drop      = w_word_done && i_fifo_full;
   // shift right so the first accepted bit ends up in bit 0 after 32 shifts
   assign w_word      = {i_bit_in, r_shift[31:1]};
   assign o_fifo_rd_en = (r_rd == R_ISSUE);

   // state registers for both FSMs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_fill <= S_IDLE;
         r_rd   <= R_IDLE;
      end else begin
         r_fill <= w_fill_next;
         r_rd   <= w_rd_next;
      end
   end

   // fill FSM next state
   always_comb begin
      w_fill_next = r_fill;
      if (!i_enable) begin
         w_fill_next = S_IDLE;
      end else begin
         case (r_fill)
            S_IDLE:    w_fill_next = S_WARMUP;
            S_WARMUP:  if (w_warm_done) w_fill_next = S_COLLECT;
            S_COLLECT: if (i_health_fail) w_fill_next = S_WARMUP;
            default:   w_fill_next = S_IDLE;
         endcase
      end
   end

   // read FSM next state
   always_comb begin
      w_rd_next = r_rd;
      case (r_rd)
         R_IDLE:  if (!i_fifo_empty) w_rd_next = R_ISSUE;
         R_ISSUE: w_rd_next = R_WAIT;
         R_WAIT:  w_rd_next = R_HOLD;
         R_HOLD:  if (o_m_valid && i_m_ready) w_rd_next = R_IDLE;
         default: w_rd_next = R_IDLE;
      endcase
   end

   // warm-up counting, word packing and FIFO write strobe
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_shift        <= '0;
         r_bit_cnt      <= '0;
         r_warm_cnt     <= '0;
         o_fifo_wr_en   <= 1'b0;
         o_fifo_wr_data <= '0;
         o_collecting   <= 1'b0;
      end else begin
         o_fifo_wr_en <= w_word_done && !i_fifo_full;
         o_collecting <= (w_fill_next == S_COLLECT);
         if (w_word_done) o_fifo_wr_data <= w_word;
         if (w_restart) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_warm_cnt <= '0;
         end else begin
            if (w_warm_bit) r_warm_cnt <= w_warm_done ? 16'd0 : r_warm_cnt + 16'd1;
            if (w_accept) begin
               r_shift   <= w_word;
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
         end
      end
   end

   // sticky overflow and saturating drop counter; a drop beats a same-cycle clear
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else if (w_drop) begin
         o_overflow <= 1'b1;
         if (i_ovf_clr)                o_drop_cnt <= CNT_W'(1);
         else if (o_drop_cnt != CNT_MAX) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
      end else if (i_ovf_clr) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end
   end

   // host output register, loaded from the registered FIFO read data
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_m_valid <= 1'b0;
         o_m_data  <= '0;
      end else if (r_rd == R_WAIT) begin
         o_m_valid <= 1'b1;
         o_m_data  <= i_fifo_rd_data;
      end else if (r_rd == R_HOLD && o_m_valid && i_m_ready) begin
         o_m_valid <= 1'b0;
      end
   end

endmodule
